// File: rtl/trigger_scheduler_if.sv
// Port bundle for the trigger scheduler: source pulses, readout handshake and status.
interface trigger_scheduler_if #(
  parameter int N_SRC     = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int SW = $clog2(N_SRC);

  logic                 enable_i;
  logic [N_SRC-1:0]     src_mask_i;
  logic [N_SRC-1:0]     src_trig_i;
  logic                 readout_ready_i;
  logic                 readout_done_i;
  logic                 clear_cnt_i;
  logic                 trigger_o;
  logic [SW-1:0]        trigger_src_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic [CNT_WIDTH-1:0] lost_count_o;

  modport master (
    output enable_i, src_mask_i, src_trig_i, readout_ready_i, readout_done_i, clear_cnt_i,
    input  trigger_o, trigger_src_o, busy_o, timeout_o, lost_count_o
  );

  modport slave (
    input  enable_i, src_mask_i, src_trig_i, readout_ready_i, readout_done_i, clear_cnt_i,
    output trigger_o, trigger_src_o, busy_o, timeout_o, lost_count_o
  );
endinterface

// File: rtl/trigger_scheduler.sv
// Round-robin arbitration of source trigger pulses into one readout trigger stream,
// with readout handshake, fixed dead time, hung-readout timeout and lost-trigger count.
module trigger_scheduler #(
  parameter int N_SRC           = 4,
  parameter int DEADTIME_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic               clk,
  input  logic               areset,
  trigger_scheduler_if.slave bus
);
  localparam int SW   = $clog2(N_SRC);
  localparam int TMAX = (TIMEOUT_CYCLES > DEADTIME_CYCLES) ? TIMEOUT_CYCLES : DEADTIME_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = CNT_WIDTH + 5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DEADTIME} state_e;

  state_e               state_q;
  logic [N_SRC-1:0]     valid;
  logic [N_SRC-1:0]     pendingMerged;
  logic [N_SRC-1:0]     pending_q, pending_d;
  logic [SW-1:0]        rrPtr_q;
  logic [SW-1:0]        grantIdx, candIdx;
  logic                 grantFound, grantNow;
  logic [TW-1:0]        timer_q;
  logic                 trigger_q, timeout_q;
  logic [SW-1:0]        triggerSrc_q;
  logic [CNT_WIDTH-1:0] lostCount_q, lostCount_d;
  logic [LW-1:0]        lostSum;

  assign valid = bus.src_trig_i & bus.src_mask_i;

  // Pulses join the pending set only in IDLE; outside IDLE they count as lost instead.
  always_comb begin
    pendingMerged = pending_q & bus.src_mask_i;
    if (state_q == IDLE) pendingMerged = pendingMerged | valid;
    if (!bus.enable_i) pendingMerged = '0;
  end

  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      candIdx = SW'((int'(rrPtr_q) + i) % N_SRC);
      if (!grantFound && pendingMerged[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign grantNow = (state_q == IDLE) && bus.enable_i && bus.readout_ready_i && grantFound;

  always_comb begin
    pending_d = pendingMerged;
    if (grantNow) pending_d[grantIdx] = 1'b0;
  end

  // Clear beats a simultaneous loss; the wide sum makes saturation detection exact.
  always_comb begin
    lostSum = LW'(lostCount_q);
    if (state_q != IDLE) begin
      for (int i = 0; i < N_SRC; i++) lostSum = lostSum + LW'(valid[i]);
    end
    if (bus.clear_cnt_i)                          lostCount_d = '0;
    else if (lostSum > LW'({CNT_WIDTH{1'b1}}))    lostCount_d = '1;
    else                                          lostCount_d = lostSum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      rrPtr_q      <= SW'(N_SRC - 1);
      timer_q      <= '0;
      trigger_q    <= 1'b0;
      timeout_q    <= 1'b0;
      triggerSrc_q <= '0;
      lostCount_q  <= '0;
    end else begin
      trigger_q   <= 1'b0;
      timeout_q   <= 1'b0;
      pending_q   <= pending_d;
      lostCount_q <= lostCount_d;
      case (state_q)
        IDLE: begin
          if (grantNow) begin
            rrPtr_q <= grantIdx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          trigger_q    <= 1'b1;
          triggerSrc_q <= rrPtr_q;
          timer_q      <= '0;
          state_q      <= WAIT_DONE;
        end
        // A done pulse in the expiry cycle takes priority, so no timeout is reported.
        WAIT_DONE: begin
          if (bus.readout_done_i) begin
            timer_q <= '0;
            state_q <= DEADTIME;
          end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
            timeout_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= DEADTIME;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DEADTIME: begin
          if (timer_q == TW'(DEADTIME_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.trigger_o     = trigger_q;
  assign bus.trigger_src_o = triggerSrc_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.timeout_o     = timeout_q;
  assign bus.lost_count_o  = lostCount_q;
endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed self-checking bench for trigger_scheduler: one task per scenario with
// hand-computed expectations (cycle offsets counted in rising edges).
module tb_trigger_scheduler;
  localparam int N_SRC     = 4;
  localparam int DEADTIME  = 16;
  localparam int TIMEOUT   = 1024;
  localparam int CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic areset;
  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  trigger_scheduler_if #(.N_SRC(N_SRC), .CNT_WIDTH(CNT_WIDTH)) bus ();

  trigger_scheduler #(
    .N_SRC(N_SRC), .DEADTIME_CYCLES(DEADTIME), .TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .areset(areset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitTrigger(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.trigger_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic waitIdle(input int limit, output bit idle);
    idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      tick();
      if (bus.busy_o === 1'b0) idle = 1'b1;
    end
  endtask

  task automatic applyReset();
    bus.enable_i        = 1'b1;
    bus.src_mask_i      = '1;
    bus.src_trig_i      = '0;
    bus.readout_ready_i = 1'b1;
    bus.readout_done_i  = 1'b0;
    bus.clear_cnt_i     = 1'b0;
    areset = 1'b1;
    ticks(2);
    areset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (bus.trigger_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_trigger: got %0b want 0", bus.trigger_o); end
    checks++; if (bus.trigger_src_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_src: got %0d want 0", bus.trigger_src_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", bus.busy_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0b want 0", bus.timeout_o); end
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_lost: got %0d want 0", bus.lost_count_o); end
  endtask

  task automatic test_single_event();
    applyReset();
    bus.src_trig_i = 4'b0100;
    tick();
    bus.src_trig_i = '0;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_issue: got %0b want 1", bus.busy_o); end
    checks++; if (bus.trigger_o !== 1'b0) begin errors++; $display("[TB] FAIL single_trig_early: got %0b want 0", bus.trigger_o); end
    tick();
    checks++; if (bus.trigger_o !== 1'b1) begin errors++; $display("[TB] FAIL single_trig: got %0b want 1", bus.trigger_o); end
    checks++; if (bus.trigger_src_o !== 2'd2) begin errors++; $display("[TB] FAIL single_src: got %0d want 2", bus.trigger_src_o); end
    tick();
    checks++; if (bus.trigger_o !== 1'b0) begin errors++; $display("[TB] FAIL single_trig_width: got %0b want 0", bus.trigger_o); end
    ticks(5);
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    // A stray done during dead time must not shorten it.
    ticks(5);
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    ticks(9);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_deadtime_busy: got %0b want 1", bus.busy_o); end
    tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_deadtime_end: got %0b want 0", bus.busy_o); end
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL single_lost: got %0d want 0", bus.lost_count_o); end
  endtask

  task automatic test_simultaneous();
    int expSrc[3] = '{0, 1, 3};
    int prevCyc = 0;
    bit seen;
    bit idle;
    applyReset();
    bus.src_trig_i = 4'b1011;
    tick();
    bus.src_trig_i = '0;
    for (int k = 0; k < 3; k++) begin
      waitTrigger(40, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL simul_trigger_%0d: got none want trigger", k); end
      checks++; if (bus.trigger_src_o !== 2'(expSrc[k])) begin errors++; $display("[TB] FAIL simul_src_%0d: got %0d want %0d", k, bus.trigger_src_o, expSrc[k]); end
      // 3 WAIT_DONE + 16 DEADTIME + 1 IDLE + 1 ISSUE cycles between triggers.
      if (k > 0) begin
        checks++; if (cycleCnt - prevCyc !== 21) begin errors++; $display("[TB] FAIL simul_spacing_%0d: got %0d want 21", k, cycleCnt - prevCyc); end
      end
      prevCyc = cycleCnt;
      ticks(2);
      bus.readout_done_i = 1'b1;
      tick();
      bus.readout_done_i = 1'b0;
    end
    waitIdle(30, idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL simul_idle: got busy want idle"); end
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL simul_lost: got %0d want 0", bus.lost_count_o); end
  endtask

  task automatic test_round_robin();
    bit seen;
    bit idle;
    applyReset();
    bus.src_trig_i = 4'b0011;
    tick();
    bus.src_trig_i = '0;
    for (int k = 0; k < 6; k++) begin
      waitTrigger(10, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL rr_trigger_%0d: got none want trigger", k); end
      checks++; if (bus.trigger_src_o !== 2'(k % 2)) begin errors++; $display("[TB] FAIL rr_src_%0d: got %0d want %0d", k, bus.trigger_src_o, k % 2); end
      tick();
      bus.readout_done_i = 1'b1;
      tick();
      bus.readout_done_i = 1'b0;
      waitIdle(30, idle);
      checks++; if (!idle) begin errors++; $display("[TB] FAIL rr_idle_%0d: got busy want idle", k); end
      if (k < 5) begin
        bus.src_trig_i = 4'b0011;
        tick();
        bus.src_trig_i = '0;
      end
    end
    waitTrigger(10, seen);
    checks++; if (!seen || bus.trigger_src_o !== 2'd0) begin errors++; $display("[TB] FAIL rr_drain: got seen=%0b src=%0d want seen=1 src=0", seen, bus.trigger_src_o); end
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL rr_lost: got %0d want 0", bus.lost_count_o); end
  endtask

  task automatic test_deadtime_loss();
    bit seen;
    bit idle;
    applyReset();
    bus.src_trig_i = 4'b0001;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(10, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL loss_trigger: got none want trigger"); end
    for (int i = 0; i < 3; i++) begin
      bus.src_trig_i = 4'b0010;
      tick();
      bus.src_trig_i = '0;
      tick();
    end
    checks++; if (bus.lost_count_o !== 16'd3) begin errors++; $display("[TB] FAIL loss_wait: got %0d want 3", bus.lost_count_o); end
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.src_trig_i = 4'b0010;
      tick();
      bus.src_trig_i = '0;
      tick();
    end
    waitIdle(30, idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL loss_idle: got busy want idle"); end
    checks++; if (bus.lost_count_o !== 16'd5) begin errors++; $display("[TB] FAIL loss_total: got %0d want 5", bus.lost_count_o); end
    waitTrigger(10, seen);
    checks++; if (seen) begin errors++; $display("[TB] FAIL loss_no_pending: got trigger want none"); end
    bus.src_trig_i = 4'b0001;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(10, seen);
    bus.src_trig_i  = 4'b0010;
    bus.clear_cnt_i = 1'b1;
    tick();
    bus.src_trig_i  = '0;
    bus.clear_cnt_i = 1'b0;
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL loss_clear_wins: got %0d want 0", bus.lost_count_o); end
  endtask

  task automatic test_saturation();
    bit reached = 1'b0;
    bit held = 1'b1;
    applyReset();
    bus.src_trig_i = '1;
    for (int i = 0; i < 20000 && !reached; i++) begin
      tick();
      if (bus.lost_count_o === 16'hFFFF) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL sat_reach: got %0h want ffff", bus.lost_count_o); end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.lost_count_o !== 16'hFFFF) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("[TB] FAIL sat_hold: got %0h want ffff", bus.lost_count_o); end
    bus.src_trig_i  = '0;
    bus.clear_cnt_i = 1'b1;
    tick();
    bus.clear_cnt_i = 1'b0;
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL sat_clear: got %0h want 0", bus.lost_count_o); end
  endtask

  task automatic test_timeout();
    bit seen;
    bit early = 1'b0;
    bit idle;
    applyReset();
    bus.src_trig_i = 4'b0100;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(10, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL to_trigger: got none want trigger"); end
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      if (bus.timeout_o !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("[TB] FAIL to_early: got pulse before expiry want none"); end
    tick();
    checks++; if (bus.timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse: got %0b want 1", bus.timeout_o); end
    tick();
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_width: got %0b want 0", bus.timeout_o); end
    ticks(14);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL to_deadtime: got %0b want 1", bus.busy_o); end
    tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL to_release: got %0b want 0", bus.busy_o); end
    bus.src_trig_i = 4'b0100;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(10, seen);
    ticks(TIMEOUT - 1);
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_done_wins: got %0b want 0", bus.timeout_o); end
    waitIdle(20, idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL to_done_idle: got busy want idle"); end
  endtask

  task automatic test_mask_enable();
    bit seen;
    bit idle;
    applyReset();
    bus.src_mask_i = 4'b0111;
    bus.src_trig_i = 4'b1000;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(8, seen);
    checks++; if (seen || bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL mask_ignored: got seen=%0b busy=%0b want 0 0", seen, bus.busy_o); end
    bus.src_trig_i = 4'b0001;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(8, seen);
    bus.src_trig_i = 4'b1000;
    tick();
    bus.src_trig_i = '0;
    checks++; if (bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL mask_not_lost: got %0d want 0", bus.lost_count_o); end
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    waitIdle(30, idle);
    bus.src_mask_i      = '1;
    bus.readout_ready_i = 1'b0;
    bus.src_trig_i      = 4'b1000;
    tick();
    bus.src_trig_i = '0;
    ticks(3);
    checks++; if (bus.busy_o !== 1'b0 || bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL notready_hold: got busy=%0b lost=%0d want 0 0", bus.busy_o, bus.lost_count_o); end
    bus.src_mask_i = 4'b0111;
    tick();
    bus.src_mask_i      = '1;
    bus.readout_ready_i = 1'b1;
    waitTrigger(8, seen);
    checks++; if (seen) begin errors++; $display("[TB] FAIL mask_clears_pending: got trigger want none"); end
    bus.readout_ready_i = 1'b0;
    bus.src_trig_i      = 4'b0010;
    tick();
    bus.src_trig_i = '0;
    ticks(4);
    bus.readout_ready_i = 1'b1;
    ticks(2);
    checks++; if (bus.trigger_o !== 1'b1 || bus.trigger_src_o !== 2'd1) begin errors++; $display("[TB] FAIL ready_release: got trig=%0b src=%0d want 1 1", bus.trigger_o, bus.trigger_src_o); end
    bus.readout_done_i = 1'b1;
    tick();
    bus.readout_done_i = 1'b0;
    waitIdle(30, idle);
    bus.enable_i   = 1'b0;
    bus.src_trig_i = 4'b0001;
    tick();
    bus.src_trig_i = '0;
    waitTrigger(8, seen);
    checks++; if (seen) begin errors++; $display("[TB] FAIL enable_off: got trigger want none"); end
    bus.enable_i = 1'b1;
    waitTrigger(8, seen);
    checks++; if (seen) begin errors++; $display("[TB] FAIL enable_dropped: got trigger want none"); end
  endtask

  task automatic test_reset_inflight();
    applyReset();
    bus.src_trig_i = 4'b0010;
    tick();
    bus.src_trig_i = 4'b0001;
    tick();
    bus.src_trig_i = '0;
    checks++; if (bus.trigger_o !== 1'b1 || bus.lost_count_o !== 16'd1) begin errors++; $display("[TB] FAIL rst_pre: got trig=%0b lost=%0d want 1 1", bus.trigger_o, bus.lost_count_o); end
    #2 areset = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.trigger_o !== 1'b0 || bus.lost_count_o !== 16'd0) begin errors++; $display("[TB] FAIL rst_async: got busy=%0b trig=%0b lost=%0d want 0 0 0", bus.busy_o, bus.trigger_o, bus.lost_count_o); end
    tick();
    areset = 1'b0;
    tick();
    bus.src_trig_i = 4'b0101;
    tick();
    bus.src_trig_i = '0;
    tick();
    checks++; if (bus.trigger_o !== 1'b1 || bus.trigger_src_o !== 2'd0) begin errors++; $display("[TB] FAIL rst_rr_start: got trig=%0b src=%0d want 1 0", bus.trigger_o, bus.trigger_src_o); end
  endtask

  initial begin
    areset = 1'b1;
    test_reset();
    test_single_event();
    test_simultaneous();
    test_round_robin();
    test_deadtime_loss();
    test_timeout();
    test_mask_enable();
    test_reset_inflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
